// File: rtl/mem_scan_ctrl.sv
// mem_scan_ctrl
//   Sequencer for the CPU debug memory read port and the display path.
//   Walks data memory one half-word at a time, either advancing on a slow
//   tick (RUN) or on a step button edge (PAUSED). For every new word address
//   it waits out the read latency and captures the 32-bit word. It then
//   presents the selected 16-bit half to the segment driver and flags it valid.
//
// Ports
//   clk        in   system clock
//   rst        in   synchronous reset, active-low
//   tick       in   one-cycle advance strobe (RUN mode)
//   pause_btn  in   debounced level, rising edge toggles RUN/PAUSED
//   step_btn   in   debounced level, rising edge advances one position (PAUSED)
//   mem_addr   out  word address to the debug read port
//   mem_data   in   read data from the debug read port
//   disp_data  out  half-word to the segment driver
//   disp_valid out  disp_data belongs to the present position
//   led        out  current word address
//   paused     out  1 = PAUSED mode
//
// All outputs come straight from flops; no input reaches an output
// combinationally.

module mem_scan_ctrl #(
  parameter int ADDR_W    = 6,
  parameter int DATA_W    = 32,
  parameter int READ_LAT  = 1,
  parameter int LAST_ADDR = 63
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              pause_btn,
  input  logic              step_btn,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic [15:0]       disp_data,
  output logic              disp_valid,
  output logic [ADDR_W-1:0] led,
  output logic              paused
);

  typedef enum logic [0:0] {
    ST_FETCH = 1'b0,
    ST_SHOW  = 1'b1
  } state_e;

  localparam int                 CNT_W    = 3;
  localparam logic [CNT_W-1:0]   CNT_INIT = CNT_W'(READ_LAT);
  localparam logic [ADDR_W-1:0]  LAST_W   = ADDR_W'(LAST_ADDR);

  // Half 0 shows the upper half-word first, half 1 the lower one.
  function automatic logic [15:0] sel_half(input logic [DATA_W-1:0] word,
                                           input logic              half);
    logic [15:0] res;
    if (half == 1'b0) begin
      res = word[31:16];
    end else begin
      res = word[15:0];
    end
    return res;
  endfunction

  state_e             state_q,      state_d;
  logic [CNT_W-1:0]   cnt_q,        cnt_d;
  logic [ADDR_W-1:0]  word_q,       word_d;
  logic               half_q,       half_d;
  logic [DATA_W-1:0]  word_reg_q,   word_reg_d;
  logic [15:0]        disp_data_q,  disp_data_d;
  logic               disp_valid_q, disp_valid_d;
  logic               paused_q,     paused_d;
  logic               pause_prev_q, pause_prev_d;
  logic               step_prev_q,  step_prev_d;

  logic pause_rise;
  logic step_rise;
  logic adv_req;

  // Next-state logic: button edges, advance request, fetch/show sequencing.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    word_d       = word_q;
    half_d       = half_q;
    word_reg_d   = word_reg_q;
    disp_data_d  = disp_data_q;
    disp_valid_d = disp_valid_q;
    pause_prev_d = pause_btn;
    step_prev_d  = step_btn;

    pause_rise = pause_btn & ~pause_prev_q;
    step_rise  = step_btn & ~step_prev_q;
    paused_d   = paused_q ^ pause_rise;

    // The mode in force before a toggle picks the advance source; a cycle
    // carrying a pause toggle never advances.
    if (paused_q) begin
      adv_req = step_rise & ~pause_rise;
    end else begin
      adv_req = tick & ~pause_rise;
    end

    case (state_q)
      ST_FETCH: begin
        // Advance requests are dropped here, not queued.
        if (cnt_q == {CNT_W{1'b0}}) begin
          word_reg_d   = mem_data;
          disp_data_d  = sel_half(mem_data, half_q);
          disp_valid_d = 1'b1;
          state_d      = ST_SHOW;
        end else begin
          cnt_d = cnt_q - CNT_W'(1'b1);
        end
      end
      ST_SHOW: begin
        if (adv_req) begin
          if (half_q == 1'b0) begin
            // Second half is already latched: no memory read needed.
            half_d      = 1'b1;
            disp_data_d = sel_half(word_reg_q, 1'b1);
          end else begin
            half_d       = 1'b0;
            disp_valid_d = 1'b0;
            cnt_d        = CNT_INIT;
            state_d      = ST_FETCH;
            if (word_q == LAST_W) begin
              word_d = {ADDR_W{1'b0}};
            end else begin
              word_d = word_q + ADDR_W'(1'b1);
            end
          end
        end else begin
          state_d = ST_SHOW;
        end
      end
      default: begin
        state_d      = ST_FETCH;
        cnt_d        = CNT_INIT;
        disp_valid_d = 1'b0;
      end
    endcase
  end

  // State registers with synchronous active-low reset. The edge detectors
  // reset to 1 so a button held through reset release gives no edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_FETCH;
      cnt_q        <= CNT_INIT;
      word_q       <= {ADDR_W{1'b0}};
      half_q       <= 1'b0;
      word_reg_q   <= {DATA_W{1'b0}};
      disp_data_q  <= 16'h0000;
      disp_valid_q <= 1'b0;
      paused_q     <= 1'b0;
      pause_prev_q <= 1'b1;
      step_prev_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      word_q       <= word_d;
      half_q       <= half_d;
      word_reg_q   <= word_reg_d;
      disp_data_q  <= disp_data_d;
      disp_valid_q <= disp_valid_d;
      paused_q     <= paused_d;
      pause_prev_q <= pause_prev_d;
      step_prev_q  <= step_prev_d;
    end
  end

  assign mem_addr   = word_q;
  assign led        = word_q;
  assign disp_data  = disp_data_q;
  assign disp_valid = disp_valid_q;
  assign paused     = paused_q;

endmodule

// File: tb/tb_mem_scan_ctrl.sv
// tb_mem_scan_ctrl
//   Directed bench for mem_scan_ctrl. Instance a (READ_LAT=1) reads from a
//   small memory array in the bench. Instance b (READ_LAT=3) gets its read
//   data driven cycle by cycle, so the capture cycle can be pinned down.

module tb_mem_scan_ctrl;

  logic        clk;
  logic        rst_a, tick_a, pause_a, step_a;
  logic [5:0]  mem_addr_a, led_a;
  logic [31:0] mem_data_a;
  logic [15:0] disp_data_a;
  logic        disp_valid_a, paused_a;

  logic        rst_b, tick_b, pause_b, step_b;
  logic [5:0]  mem_addr_b, led_b;
  logic [31:0] mem_data_b;
  logic [15:0] disp_data_b;
  logic        disp_valid_b, paused_b;

  logic [31:0] mem_a [0:63];

  int n_tests;
  int n_fail;
  int pos_w;
  int pos_h;

  mem_scan_ctrl #(.ADDR_W(6), .DATA_W(32), .READ_LAT(1), .LAST_ADDR(63)) dut_a (
    .clk(clk), .rst(rst_a), .tick(tick_a), .pause_btn(pause_a), .step_btn(step_a),
    .mem_addr(mem_addr_a), .mem_data(mem_data_a), .disp_data(disp_data_a),
    .disp_valid(disp_valid_a), .led(led_a), .paused(paused_a)
  );

  mem_scan_ctrl #(.ADDR_W(6), .DATA_W(32), .READ_LAT(3), .LAST_ADDR(63)) dut_b (
    .clk(clk), .rst(rst_b), .tick(tick_b), .pause_btn(pause_b), .step_btn(step_b),
    .mem_addr(mem_addr_b), .mem_data(mem_data_b), .disp_data(disp_data_b),
    .disp_valid(disp_valid_b), .led(led_b), .paused(paused_b)
  );

  assign mem_data_a = mem_a[mem_addr_a];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One clock; outputs settle and are sampled 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid_a();
    int n;
    n = 0;
    while (!disp_valid_a && n < 10) begin
      cyc();
      n++;
    end
    check("wait_valid_a", {31'd0, disp_valid_a}, 32'd1);
  endtask

  function automatic logic [15:0] exp_half(input int w, input int h);
    logic [31:0] v;
    v = mem_a[w];
    return (h == 0) ? v[31:16] : v[15:0];
  endfunction

  // Tick once in RUN mode and follow the position in the bench model.
  task automatic adv_a();
    tick_a = 1'b1;
    cyc();
    tick_a = 1'b0;
    if (pos_h == 0) begin
      pos_h = 1;
    end else begin
      pos_h = 0;
      pos_w = (pos_w == 63) ? 0 : pos_w + 1;
    end
    if (!disp_valid_a) wait_valid_a();
    check("adv_data", {16'd0, disp_data_a}, {16'd0, exp_half(pos_w, pos_h)});
    check("adv_addr", {26'd0, mem_addr_a}, 32'(pos_w));
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    for (int i = 0; i < 64; i++) begin
      mem_a[i] = {16'h1000 + 16'(i), 16'h2000 + 16'(i)};
    end
    mem_a[0] = 32'h1234_5678;
    mem_a[1] = 32'hCAFE_BEEF;

    rst_a = 1'b0; tick_a = 1'b0; pause_a = 1'b0; step_a = 1'b0;
    rst_b = 1'b0; tick_b = 1'b0; pause_b = 1'b0; step_b = 1'b0;
    mem_data_b = 32'h0000_0000;

    // Reset state
    cyc();
    cyc();
    check("rst_valid",  {31'd0, disp_valid_a}, 32'd0);
    check("rst_data",   {16'd0, disp_data_a},  32'd0);
    check("rst_led",    {26'd0, led_a},        32'd0);
    check("rst_addr",   {26'd0, mem_addr_a},   32'd0);
    check("rst_paused", {31'd0, paused_a},     32'd0);

    // First fetch after release: valid low for 2 edges, then upper half
    rst_a = 1'b1;
    cyc();
    check("fetch0_e1_valid", {31'd0, disp_valid_a}, 32'd0);
    cyc();
    check("fetch0_e2_valid", {31'd0, disp_valid_a}, 32'd1);
    check("fetch0_data",     {16'd0, disp_data_a},  32'h1234);
    check("fetch0_led",      {26'd0, led_a},        32'd0);

    // Half step: lower half at once, valid never drops
    tick_a = 1'b1;
    cyc();
    tick_a = 1'b0;
    check("half_data",  {16'd0, disp_data_a},  32'h5678);
    check("half_valid", {31'd0, disp_valid_a}, 32'd1);

    // Word crossing with ticks held during the fetch
    tick_a = 1'b1;
    cyc();
    check("cross_addr",     {26'd0, mem_addr_a},   32'd1);
    check("cross_valid_e0", {31'd0, disp_valid_a}, 32'd0);
    cyc();
    check("cross_valid_e1", {31'd0, disp_valid_a}, 32'd0);
    cyc();
    tick_a = 1'b0;
    check("cross_valid_e2", {31'd0, disp_valid_a}, 32'd1);
    check("cross_data",     {16'd0, disp_data_a},  32'hCAFE);
    cyc();
    check("cross_hold_data", {16'd0, disp_data_a}, 32'hCAFE);
    check("cross_hold_addr", {26'd0, mem_addr_a},  32'd1);

    // Walk to (63,1) then wrap
    pos_w = 1;
    pos_h = 0;
    for (int k = 0; k < 125; k++) adv_a();
    check("pre_wrap_addr", {26'd0, mem_addr_a}, 32'd63);
    tick_a = 1'b1;
    cyc();
    tick_a = 1'b0;
    check("wrap_addr",  {26'd0, mem_addr_a},   32'd0);
    check("wrap_led",   {26'd0, led_a},        32'd0);
    check("wrap_valid", {31'd0, disp_valid_a}, 32'd0);
    wait_valid_a();
    check("wrap_data",  {16'd0, disp_data_a},  32'h1234);

    // Pause, ignored ticks, single step, held step, resume
    pause_a = 1'b1;
    cyc();
    check("pause_on", {31'd0, paused_a}, 32'd1);
    tick_a = 1'b1;
    repeat (10) cyc();
    tick_a = 1'b0;
    check("paused_tick_data", {16'd0, disp_data_a}, 32'h1234);
    check("paused_tick_addr", {26'd0, mem_addr_a},  32'd0);
    step_a = 1'b1;
    cyc();
    check("step_data", {16'd0, disp_data_a}, 32'h5678);
    repeat (20) cyc();
    check("step_held_data", {16'd0, disp_data_a}, 32'h5678);
    check("step_held_addr", {26'd0, mem_addr_a},  32'd0);
    step_a  = 1'b0;
    pause_a = 1'b0;
    cyc();
    pause_a = 1'b1;
    cyc();
    check("pause_off", {31'd0, paused_a}, 32'd0);
    pause_a = 1'b0;
    cyc();

    // Pause rise together with tick while RUN
    pause_a = 1'b1;
    tick_a  = 1'b1;
    cyc();
    tick_a = 1'b0;
    check("sim1_paused", {31'd0, paused_a},    32'd1);
    check("sim1_data",   {16'd0, disp_data_a}, 32'h5678);
    check("sim1_addr",   {26'd0, mem_addr_a},  32'd0);
    pause_a = 1'b0;
    cyc();

    // Step rise together with pause rise while PAUSED
    step_a  = 1'b1;
    pause_a = 1'b1;
    cyc();
    check("sim2_paused", {31'd0, paused_a},     32'd0);
    check("sim2_data",   {16'd0, disp_data_a},  32'h5678);
    check("sim2_valid",  {31'd0, disp_valid_a}, 32'd1);
    step_a  = 1'b0;
    pause_a = 1'b0;
    cyc();

    // Reset during the fetch of word 5, pause held high across it
    pos_w = 0;
    pos_h = 1;
    repeat (8) adv_a();
    tick_a = 1'b1;
    cyc();
    tick_a = 1'b0;
    check("pre_rst_addr",  {26'd0, mem_addr_a},   32'd5);
    check("pre_rst_valid", {31'd0, disp_valid_a}, 32'd0);
    pause_a = 1'b1;
    rst_a   = 1'b0;
    cyc();
    check("mid_rst_data",   {16'd0, disp_data_a},  32'd0);
    check("mid_rst_valid",  {31'd0, disp_valid_a}, 32'd0);
    check("mid_rst_led",    {26'd0, led_a},        32'd0);
    check("mid_rst_addr",   {26'd0, mem_addr_a},   32'd0);
    check("mid_rst_paused", {31'd0, paused_a},     32'd0);
    rst_a = 1'b1;
    repeat (3) cyc();
    check("post_rst_paused", {31'd0, paused_a},    32'd0);
    check("post_rst_data",   {16'd0, disp_data_a}, 32'h1234);
    pause_a = 1'b0;
    cyc();
    pause_a = 1'b1;
    cyc();
    check("post_rst_pause_on", {31'd0, paused_a}, 32'd1);
    pause_a = 1'b0;

    // READ_LAT=3: capture on the 4th edge, mem_data sampled only there
    rst_b = 1'b0;
    cyc();
    check("b_rst_valid", {31'd0, disp_valid_b}, 32'd0);
    rst_b = 1'b1;
    for (int j = 1; j <= 4; j++) begin
      mem_data_b = {16'hA000 + 16'(j), 16'h5000 + 16'(j)};
      cyc();
      check("b_fetch0_valid", {31'd0, disp_valid_b}, (j == 4) ? 32'd1 : 32'd0);
    end
    check("b_fetch0_data", {16'd0, disp_data_b}, 32'hA004);
    mem_data_b = 32'hFFFF_FFFF;
    cyc();
    check("b_hold_data", {16'd0, disp_data_b}, 32'hA004);
    tick_b = 1'b1;
    cyc();
    tick_b = 1'b0;
    check("b_half_data", {16'd0, disp_data_b}, 32'h5004);
    tick_b = 1'b1;
    cyc();
    tick_b = 1'b0;
    check("b_cross_addr",  {26'd0, mem_addr_b},   32'd1);
    check("b_cross_valid", {31'd0, disp_valid_b}, 32'd0);
    for (int j = 1; j <= 4; j++) begin
      mem_data_b = {16'hB000 + 16'(j), 16'h6000 + 16'(j)};
      cyc();
      check("b_fetch1_valid", {31'd0, disp_valid_b}, (j == 4) ? 32'd1 : 32'd0);
    end
    check("b_fetch1_data", {16'd0, disp_data_b}, 32'hB004);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
